// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
//   ID stage of a classic five-stage MIPS-style pipeline. It contains the
//   32 x 32 register file, the opcode decoder, the load-use hazard detector
//   and the ID/EX pipeline register.
//
//   Ports
//     clock          sole clock, all state updates on the rising edge
//     reset          synchronous, active-low; clears ID/EX and the register file
//     IF_ID[63:32]   PC+4 of the instruction in decode
//     IF_ID[31:0]    instruction word
//     flush          branch/jump taken in EX; squash the instruction in decode
//     wb_en/addr/data  register-file write port from writeback
//     stall          combinational; fetch must hold PC and IF_ID
//     id_ex_*        registered ID/EX fields (pc, read data, imm, rs/rt/rd)
//     id_ex_ctrl     [0] reg_write [1] mem_read [2] mem_write [3] mem_to_reg
//                    [4] alu_src [5] reg_dst [6] branch [7] jump
//     illegal        registered; opcode of the decoded instruction unsupported
//
//   Build option
//     REGFILE_BYPASS_EN  when defined, a same-cycle writeback to the register
//                        being read is forwarded to the read port; otherwise
//                        the read port returns the pre-write value.
// -----------------------------------------------------------------------------
module instruction_decode (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] IF_ID,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd,
  output logic [7:0]  id_ex_ctrl,
  output logic        illegal
);

  logic [31:0] regs_r [32];

  logic [31:0] instr_s;
  logic [31:0] pc_s;
  logic [5:0]  opcode_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [31:0] imm_s;
  logic [31:0] rs_data_s;
  logic [31:0] rt_data_s;
  logic [7:0]  ctrl_dec_s;
  logic        illegal_dec_s;
  logic        stall_s;
  logic [7:0]  ctrl_next_s;
  logic        illegal_next_s;

  // Split the fetch register into its fields and sign-extend the immediate.
  always_comb begin
    pc_s     = IF_ID[63:32];
    instr_s  = IF_ID[31:0];
    opcode_s = instr_s[31:26];
    rs_s     = instr_s[25:21];
    rt_s     = instr_s[20:16];
    rd_s     = instr_s[15:11];
    imm_s    = {{16{instr_s[15]}}, instr_s[15:0]};
  end

  // Register-file read ports; r0 is hard-wired to zero.
  always_comb begin
    rs_data_s = 32'd0;
    rt_data_s = 32'd0;
    if (rs_s == 5'd0) begin
      rs_data_s = 32'd0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wb_en && (wb_addr == rs_s)) begin
      rs_data_s = wb_data;
    end
`endif
    else begin
      rs_data_s = regs_r[rs_s];
    end

    if (rt_s == 5'd0) begin
      rt_data_s = 32'd0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wb_en && (wb_addr == rt_s)) begin
      rt_data_s = wb_data;
    end
`endif
    else begin
      rt_data_s = regs_r[rt_s];
    end
  end

  // Opcode decoder; anything outside the supported set is flagged illegal.
  always_comb begin
    ctrl_dec_s    = 8'h00;
    illegal_dec_s = 1'b0;
    case (opcode_s)
      6'h00:   ctrl_dec_s = 8'h21;  // R-type
      6'h23:   ctrl_dec_s = 8'h1B;  // lw
      6'h2B:   ctrl_dec_s = 8'h14;  // sw
      6'h04:   ctrl_dec_s = 8'h40;  // beq
      6'h08:   ctrl_dec_s = 8'h11;  // addi
      6'h02:   ctrl_dec_s = 8'h80;  // j
      default: begin
        ctrl_dec_s    = 8'h00;
        illegal_dec_s = 1'b1;
      end
    endcase
  end

  // Load-use hazard: the load in EX writes a register this instruction reads.
  // A flush squashes the instruction anyway, so it suppresses the stall.
  always_comb begin
    stall_s = 1'b0;
    if (!flush && id_ex_ctrl[1] && (id_ex_rt != 5'd0) &&
        ((id_ex_rt == rs_s) || (id_ex_rt == rt_s))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign stall = stall_s;

  // Flush or stall turns the decoded instruction into a bubble.
  always_comb begin
    ctrl_next_s    = 8'h00;
    illegal_next_s = 1'b0;
    if (flush || stall_s) begin
      ctrl_next_s    = 8'h00;
      illegal_next_s = 1'b0;
    end else begin
      ctrl_next_s    = ctrl_dec_s;
      illegal_next_s = illegal_dec_s;
    end
  end

  // ID/EX pipeline register; data fields load even on a bubble.
  always_ff @(posedge clock) begin
    if (!reset) begin
      id_ex_pc      <= 32'd0;
      id_ex_rs_data <= 32'd0;
      id_ex_rt_data <= 32'd0;
      id_ex_imm     <= 32'd0;
      id_ex_rs      <= 5'd0;
      id_ex_rt      <= 5'd0;
      id_ex_rd      <= 5'd0;
      id_ex_ctrl    <= 8'h00;
      illegal       <= 1'b0;
    end else begin
      id_ex_pc      <= pc_s;
      id_ex_rs_data <= rs_data_s;
      id_ex_rt_data <= rt_data_s;
      id_ex_imm     <= imm_s;
      id_ex_rs      <= rs_s;
      id_ex_rt      <= rt_s;
      id_ex_rd      <= rd_s;
      id_ex_ctrl    <= ctrl_next_s;
      illegal       <= illegal_next_s;
    end
  end

  // Register-file write port; writes to r0 and writes during reset are dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else begin
      if (wb_en && (wb_addr != 5'd0)) begin
        regs_r[wb_addr] <= wb_data;
      end
    end
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-003 IF_ID  input  64  fetch pipeline register; [63:32] = PC+4, [31:0] = instruction word.
REQ-004 flush  input  1  from EX; branch/jump taken, squash current decode.
REQ-005 wb_en  input  1  writeback write enable.
REQ-006 wb_addr  input  5  writeback destination register.
REQ-007 wb_data  input  32  writeback data.
REQ-008 stall  output  1  combinational; 1 = fetch must hold PC and IF_ID.
REQ-009 id_ex_pc  output  32  registered PC+4.
REQ-010 id_ex_rs_data, id_ex_rt_data  output  32 each  registered register-file read data.
REQ-011 id_ex_imm  output  32  registered sign-extended instruction[15:0].
REQ-012 id_ex_rs, id_ex_rt, id_ex_rd  output  5 each  registered register fields.
REQ-013 id_ex_ctrl  output  8  registered control: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [5] reg_dst, [6] branch, [7] jump.
REQ-014 illegal  output  1  registered; 1 = decoded opcode unsupported.

Function
REQ-015 Register file SHALL be 32 x 32 bit, two combinational read ports (rs = instr[25:21], rt = instr[20:16]), one write port.
REQ-016 Writes SHALL occur at rising edge when wb_en=1 and wb_addr!=0; register 0 SHALL always read 0.
REQ-017 Decode by opcode instr[31:26]: 0x00 R-type ctrl=0x21; 0x23 lw ctrl=0x1B; 0x2B sw ctrl=0x14; 0x04 beq ctrl=0x40; 0x08 addi ctrl=0x11; 0x02 j ctrl=0x80.
REQ-018 Any other opcode SHALL produce ctrl=0x00 and illegal=1; illegal=0 otherwise.
REQ-019 All id_ex_* outputs SHALL load with one-cycle latency from IF_ID.
REQ-020 Load-use hazard: stall=1 when id_ex_ctrl[1]=1, id_ex_rt!=0, and id_ex_rt equals current rs or rt; otherwise stall=0.
REQ-021 On stall, next id_ex_ctrl SHALL be 0x00 (bubble), illegal=0; data fields may update; stall SHALL self-clear next cycle.
REQ-022 On flush=1, next id_ex_ctrl SHALL be 0x00 and illegal=0; flush SHALL take priority over stall, and stall SHALL be forced 0 while flush=1.
REQ-023 Register-file write and ID/EX update in the same cycle SHALL both take effect.

Reset
REQ-024 While reset=0 at rising edge: all id_ex_* outputs and illegal SHALL clear to 0, and all 32 registers SHALL clear to 0.
REQ-025 Reset SHALL override flush, stall and wb_en; writeback during reset SHALL be discarded.
REQ-026 stall SHALL read 0 in the first cycle after reset deasserts (id_ex_ctrl=0).

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: when wb_en=1, wb_addr!=0 and wb_addr equals rs/rt, the read port SHALL return wb_data in the same cycle.
REQ-028 Macro REGFILE_BYPASS_EN undefined: the read port SHALL return the pre-write value; the new value SHALL be visible from the following cycle.

Verification
REQ-029 Reset: hold reset=0 for 3 cycles with wb_en=1, wb_addr=5, wb_data=0xFFFFFFFF -> all outputs 0; r5 reads 0 afterwards.
REQ-030 lw decode: IF_ID={0x00000008, 0x8C430010} -> next cycle id_ex_ctrl=0x1B, rs=2, rt=3, imm=0x00000010, pc=0x00000008.
REQ-031 Sign extension: instruction 0x2022FFFC -> id_ex_ctrl=0x11, id_ex_imm=0xFFFFFFFC.
REQ-032 Load-use: lw r3 followed by add r4,r3,r1 (0x00612020) -> stall=1 for exactly one cycle, bubble ctrl=0x00, then the add issues with ctrl=0x21.
REQ-033 Flush: flush=1 with a valid beq in IF_ID -> id_ex_ctrl=0x00; flush during load-use -> stall=0.
REQ-034 Bypass: wb_en=1, wb_addr=7, wb_data=0x12345678, decode reads r7 in the same cycle -> id_ex_rs_data=0x12345678 with REGFILE_BYPASS_EN, old value without; writing r0 reads back 0.
